// File: rtl/tag_pkg.sv
// Shared types and constants for the A/B tag issuer.
// Tags are 16 bits wide and each table holds eight entries.
package tag_pkg;

    localparam int TAGW  = 16;
    localparam int NSLOT = 8;
    localparam int SLOTW = 3;

    typedef logic [TAGW-1:0]  tag_t;
    typedef logic [SLOTW-1:0] slot_t;

    localparam tag_t TAG_INIT_DEF = 16'h0000;

endpackage

// File: rtl/tag_pick_free.sv
// Lowest-index free-slot finder for one tag table.
// The finder uses the registered valid bits only.
module tag_pick_free
    import tag_pkg::*;
(
    input  logic [NSLOT-1:0] vld,
    output logic             found,
    output slot_t            slot
);

    // Scan downward so the lowest free index is the one left standing.
    always_comb begin
        found = 1'b0;
        slot  = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!vld[i]) begin
                found = 1'b1;
                slot  = slot_t'(i);
            end
        end
    end

endmodule

// File: rtl/tag_issuer.sv
// Allocates unique tags into tables A and B from a wrapping counter.
// Any candidate that matches a live tag is skipped for good.
module tag_issuer #(
    parameter int               TAGW     = 16,
    parameter int               NSLOT    = 8,
    parameter logic [TAGW-1:0]  TAG_INIT = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       req_a,
    input  logic                       req_b,
    input  logic [NSLOT-1:0]           ret_a,
    input  logic [NSLOT-1:0]           ret_b,
    output logic                       gnt_a,
    output logic                       gnt_b,
    output logic [2:0]                 gnt_slot_a,
    output logic [2:0]                 gnt_slot_b,
    output logic [TAGW-1:0]            gnt_tag_a,
    output logic [TAGW-1:0]            gnt_tag_b,
    output logic [NSLOT-1:0]           vlda,
    output logic [NSLOT-1:0]           vldb,
    output logic [NSLOT-1:0][TAGW-1:0] taga,
    output logic [NSLOT-1:0][TAGW-1:0] tagb
);

    import tag_pkg::*;

    logic [TAGW-1:0]            ctr_q;
    logic [TAGW-1:0]            ctr_nxt;
    logic [NSLOT-1:0]           vlda_q;
    logic [NSLOT-1:0]           vldb_q;
    logic [NSLOT-1:0]           vlda_nxt;
    logic [NSLOT-1:0]           vldb_nxt;
    logic [NSLOT-1:0][TAGW-1:0] taga_q;
    logic [NSLOT-1:0][TAGW-1:0] tagb_q;

    logic                       found_a;
    logic                       found_b;
    slot_t                      free_a;
    slot_t                      free_b;
    logic                       offer_a;
    logic                       offer_b;
    logic [TAGW-1:0]            cand_a;
    logic [TAGW-1:0]            cand_b;
    logic                       hit_a;
    logic                       hit_b;
    logic                       win_a;
    logic                       win_b;
    logic [NSLOT-1:0]           set_a;
    logic [NSLOT-1:0]           set_b;

    tag_pick_free u_free_a (
        .vld   (vlda_q),
        .found (found_a),
        .slot  (free_a)
    );

    tag_pick_free u_free_b (
        .vld   (vldb_q),
        .found (found_b),
        .slot  (free_b)
    );

    assign offer_a = req_a & found_a;
    assign offer_b = req_b & found_b;

    // B only takes ctr+1 when A is also consuming a counter value.
    assign cand_a = ctr_q;
    assign cand_b = offer_a ? ctr_q + {{(TAGW-1){1'b0}}, 1'b1}
                            : ctr_q;

    // Retiring entries still count as live here; that is safe.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (vlda_q[i] && (taga_q[i] == cand_a)) hit_a = 1'b1;
            if (vldb_q[i] && (tagb_q[i] == cand_a)) hit_a = 1'b1;
            if (vlda_q[i] && (taga_q[i] == cand_b)) hit_b = 1'b1;
            if (vldb_q[i] && (tagb_q[i] == cand_b)) hit_b = 1'b1;
        end
    end

    assign win_a = offer_a & ~hit_a;
    assign win_b = offer_b & ~hit_b;

    assign ctr_nxt = ctr_q
                   + {{(TAGW-1){1'b0}}, offer_a}
                   + {{(TAGW-1){1'b0}}, offer_b};

    always_comb begin
        set_a         = '0;
        set_b         = '0;
        set_a[free_a] = win_a;
        set_b[free_b] = win_b;
    end

    // The grant slot was free, so a retire bit on it changes nothing.
    assign vlda_nxt = (vlda_q & ~ret_a) | set_a;
    assign vldb_nxt = (vldb_q & ~ret_b) | set_b;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctr_q  <= TAG_INIT;
            vlda_q <= '0;
            vldb_q <= '0;
        end else begin
            ctr_q  <= ctr_nxt;
            vlda_q <= vlda_nxt;
            vldb_q <= vldb_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            taga_q <= '0;
            tagb_q <= '0;
        end else begin
            if (win_a) taga_q[free_a] <= cand_a;
            if (win_b) tagb_q[free_b] <= cand_b;
        end
    end

    assign gnt_a      = win_a;
    assign gnt_b      = win_b;
    assign gnt_slot_a = win_a ? free_a : '0;
    assign gnt_slot_b = win_b ? free_b : '0;
    assign gnt_tag_a  = win_a ? cand_a : '0;
    assign gnt_tag_b  = win_b ? cand_b : '0;

    assign vlda = vlda_q;
    assign vldb = vldb_q;
    assign taga = taga_q;
    assign tagb = tagb_q;

endmodule

// File: doc/tag_issuer.md
# tag_issuer

Allocates 16-bit tags into two 8-entry tag tables (A and B) and retires them. It guarantees that no tag is ever live twice, either across the two tables or within one table. It is the producer side of the A/B tag-table interface, and its `vlda/vldb/taga/tagb` outputs feed the tag-uniqueness checker directly. Tags come from a wrapping counter, and any candidate that collides with a live entry is skipped.

## Interface
Parameters:
- `TAGW`, 16, tag width
- `NSLOT`, 8, entries per table (fixed at 8 for this design)
- `TAG_INIT`, 16'h0000, counter value after reset

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset; asynchronous, active-low
- `req_a`  in  1  request one allocation in table A (level)
- `req_b`  in  1  request one allocation in table B (level)
- `ret_a`  in  8  retire mask, table A; bit i clears entry i
- `ret_b`  in  8  retire mask, table B
- `gnt_a`  out  1  allocation in A accepted this cycle
- `gnt_b`  out  1  allocation in B accepted this cycle
- `gnt_slot_a`  out  3  slot written in A when `gnt_a`
- `gnt_slot_b`  out  3  slot written in B when `gnt_b`
- `gnt_tag_a`  out  16  tag written in A when `gnt_a`
- `gnt_tag_b`  out  16  tag written in B when `gnt_b`
- `vlda`  out  8  valid bits, table A (registered)
- `vldb`  out  8  valid bits, table B (registered)
- `taga`  out  [7:0][15:0]  tag table A (registered)
- `tagb`  out  [7:0][15:0]  tag table B (registered)

## Operation
- **State.** `ctr` (16 b), plus `vld`/`tag` for each table. There is no other FSM. The block runs in a single state, ISSUE, whenever `rstn` is high.
- **Free slot.** Lowest index i with `vld[i]==0`, computed from *registered* valid bits. A slot being retired this cycle is not free until the next cycle.
- **Offer.** A request is *offered* when `req_x` is high and its table has a free slot.
- **Candidates.**
  - `cand0 = ctr`, `cand1 = ctr+1` (mod 2^16).
  - If both A and B are offered: A takes `cand0`, B takes `cand1`.
  - If only one is offered, it takes `cand0`.
- **Hit.** A candidate hits if it equals `tag` of any entry with registered `vld=1` in either table. Entries retiring this cycle still count, which is conservative.
- **Grant.** `gnt_x = offered_x & !hit(cand_x)`.
  - `gnt_slot_x` and `gnt_tag_x` are valid only while `gnt_x` is high; otherwise they are driven to 0.
- **Counter update.** `ctr_next = ctr + (#offered)`. This applies whether or not the offer hit, so a colliding value is skipped permanently and the counter always makes progress.
- **Table update at the next edge.**
  - Retire clears `vld[i]` when the corresponding `ret_x[i]` is set.
  - A grant sets `vld[slot]` and writes `tag[slot]`.
  - The grant slot is never a slot being retired, because the free slot is taken from registered state.
  - Tag contents of cleared entries are retained and are don't-care.
- **Full table.** No offer is made, `gnt` stays low and `ctr` does not advance for that port. The requester holds `req`.
- **Retire of an invalid entry.** No effect.
- **Invariant (verification).** Among valid entries, all 16 tags are pairwise distinct at every cycle.

## Timing
- **Reset (async assert, sync deassert).**
  - `vlda`, `vldb` = 0; `taga`, `tagb` = 0; `ctr = TAG_INIT`.
  - All `gnt*` outputs = 0, because their inputs gate to 0 with empty-of-requests logic and registered state cleared.
  - Reset in mid-operation discards all live tags immediately.
- **Grant latency.** 0 cycles: `gnt_x` is combinational from `req_x` and registered state.
  - The entry appears in `vld`/`tag` one cycle later.
  - `ctr` moves one cycle later.
- **Throughput.** Up to one allocation per table per cycle.
- **Retire latency.** `vld` clears 1 cycle after `ret`. The slot becomes allocatable in that same following cycle.
- **Wrap-around.**
  - `ctr` wraps FFFF→0000.
  - With `ctr=FFFF` and both ports offered, A gets FFFF, B gets 0000, and `ctr_next = 0001`.

## Structure
- **Package `tag_pkg`:**
  - `tag_t` (logic [15:0])
  - `slot_t` (logic [2:0])
  - `NSLOT = 8`
  - `TAG_INIT` default
- **Sub-module `tag_pick_free`:** 8-bit valid vector in; outputs `found` and the lowest free `slot_t`. It is instantiated once per table.
- **Hit comparison:** done by 16 equality comparators per candidate inside `tag_issuer`.

## Test plan
- **Reset then single A request.** Reset, then `req_a=1` for 1 cycle → `gnt_a=1`, `slot=0`, `tag=0000`; the next cycle shows `vlda=01`, `taga[0]=0000`, and `ctr=0001`.
- **Simultaneous requests.** `req_a=req_b=1` for 3 cycles → A receives tags 0,2,4 in slots 0,1,2; B receives tags 1,3,5 in slots 0,1,2; `ctr=6`.
- **Full table.** Fill A (8 grants), then hold `req_a` → `gnt_a=0` and `ctr` is frozen. Pulse `ret_a=8'h10` → the cycle after `vlda` bit 4 clears, A is granted slot 4 with tag 8.
- **Collision skip.**
  - Setup: `TAG_INIT=16'hFFFE`. Allocate A slot 0 with tag FFFE and leave it live.
  - Run other traffic until `ctr` returns to FFFE.
  - Stimulus: `req_b=1` → `gnt_b=0` for that cycle and `ctr` becomes FFFF.
  - Next cycle: B is granted tag FFFF.
- **Wrap.** `ctr=FFFF` with both ports requesting → A gets FFFF, B gets 0000.
- **Mid-operation reset.** Drop `rstn` low with 5 entries live → `vld` is 0 immediately and asynchronously. After release, the first grant carries `tag=TAG_INIT`.
